// File: rtl/lsu_mem_if.sv
// Load/store unit between EX and the data-memory bus: one valid/ready transaction per
// memory instruction, with alignment faulting, lane steering and load extension.
module lsu_mem_if #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [1:0]        mem_len,
    input  logic              mem_sign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic              misalign,
    output logic [31:0]       rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic              m_rvalid,
    input  logic [31:0]       m_rdata
);
    localparam int unsigned LEN_W = 2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         lane_q;
    logic [LEN_W-1:0]   len_q;
    logic               sign_q;
    logic               fault_q;
    logic               op_c;
    logic               misaligned_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_rep_c;

    // Select and extend the addressed byte/half of a returned read word.
    function automatic logic [31:0] format_load(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [LEN_W-1:0] len, input logic sign);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (len)
            2'd0:    format_load = {{24{sign & b[7]}}, b};
            2'd1:    format_load = {{16{sign & h[15]}}, h};
            default: format_load = word;
        endcase
    endfunction

    assign op_c = req_valid & (req_load | req_store);

    // Request decode: alignment, byte enables and lane replication.
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'hF;
        wdata_rep_c  = wdata;
        case (mem_len)
            2'd0: begin
                be_c        = 4'(4'b0001 << addr[1:0]);
                wdata_rep_c = {4{wdata[7:0]}};
            end
            2'd1: begin
                misaligned_c = addr[0];
                be_c         = 4'(4'b0011 << addr[1:0]);
                wdata_rep_c  = {2{wdata[15:0]}};
            end
            default: misaligned_c = |addr[1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (op_c) state_nxt = misaligned_c ? S_DONE : S_REQ;
            S_REQ: begin
                if (m_ready) begin
                    if (m_we || m_rvalid) state_nxt = S_DONE;
                    else                  state_nxt = S_WAIT;
                end
            end
            S_WAIT:  if (m_rvalid) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // DONE never looks at the request, so a still-presented instruction is not re-accepted.
    always_comb begin
        m_valid  = (state == S_REQ);
        done     = (state == S_DONE);
        misalign = (state == S_DONE) & fault_q;
        stall    = ((state == S_IDLE) & op_c) | (state == S_REQ) | (state == S_WAIT);
    end

    // Request latch and load-result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_be    <= 4'h0;
            m_wdata <= 32'h0;
            rdata   <= 32'h0;
            lane_q  <= 2'b00;
            len_q   <= '0;
            sign_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_c) begin
                        if (misaligned_c) begin
                            fault_q <= 1'b1;
                        end else begin
                            m_we    <= req_store;
                            m_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            m_be    <= be_c;
                            m_wdata <= wdata_rep_c;
                            lane_q  <= addr[1:0];
                            len_q   <= mem_len;
                            sign_q  <= mem_sign;
                        end
                    end
                end
                S_REQ: begin
                    if (m_ready && !m_we && m_rvalid)
                        rdata <= format_load(m_rdata, lane_q, len_q, sign_q);
                end
                S_WAIT: begin
                    if (m_rvalid)
                        rdata <= format_load(m_rdata, lane_q, len_q, sign_q);
                end
                S_DONE:  fault_q <= 1'b0;
                default: fault_q <= 1'b0;
            endcase
        end
    end
endmodule
